// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute FSM with a memory request/ack handshake
// and a small return-address stack for call/ret.
module pc_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int SPW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fetch_ack,
    input  logic             op_jump,
    input  logic             op_call,
    input  logic             op_ret,
    input  logic             op_halt,
    input  logic [WIDTH-1:0] target,
    output logic             fetch_req,
    output logic [WIDTH-1:0] fetch_addr,
    output logic [WIDTH-1:0] pc,
    output logic [SPW-1:0]   sp,
    output logic             busy,
    output logic             halted,
    output logic             fault
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, FAULT} state_t;

    state_t                    state, state_n;
    logic [DEPTH-1:0][WIDTH-1:0] stack;
    logic                      lat_jump, lat_call, lat_ret, lat_halt;
    logic [WIDTH-1:0]          lat_target, top, pc_inc;
    logic                      ret_ok, call_ok;

    assign fetch_addr = pc;
    assign pc_inc     = pc + WIDTH'(1);
    assign ret_ok     = (sp != '0);
    assign call_ok    = (sp != SPW'(DEPTH));

    // Entry below the stack pointer, i.e. the most recent return address.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sp == SPW'(i + 1)) top = stack[i];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = FETCH;
            FETCH: if (fetch_ack) state_n = EXEC;
            EXEC: begin
                if (lat_halt)      state_n = HALT;
                else if (lat_ret)  state_n = ret_ok  ? FETCH : FAULT;
                else if (lat_call) state_n = call_ok ? FETCH : FAULT;
                else               state_n = FETCH;
            end
            HALT:  if (start) state_n = FETCH;
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= '0;
            sp         <= '0;
            stack      <= '0;
            lat_jump   <= 1'b0;
            lat_call   <= 1'b0;
            lat_ret    <= 1'b0;
            lat_halt   <= 1'b0;
            lat_target <= '0;
            fetch_req  <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state     <= state_n;
            fetch_req <= (state_n == FETCH);
            busy      <= (state_n == FETCH) || (state_n == EXEC);
            halted    <= (state_n == HALT);
            fault     <= (state_n == FAULT);

            if (state == FETCH && fetch_ack) begin
                lat_jump   <= op_jump;
                lat_call   <= op_call;
                lat_ret    <= op_ret;
                lat_halt   <= op_halt;
                lat_target <= target;
            end

            // Resume after the halt instruction rather than re-executing it.
            if (state == HALT && start) pc <= pc_inc;

            if (state == EXEC && !lat_halt) begin
                if (lat_ret) begin
                    if (ret_ok) begin
                        pc <= top;
                        sp <= sp - SPW'(1);
                    end
                end else if (lat_call) begin
                    if (call_ok) begin
                        for (int i = 0; i < DEPTH; i++)
                            if (sp == SPW'(i)) stack[i] <= pc_inc;
                        sp <= sp + SPW'(1);
                        pc <= lat_target;
                    end
                end else if (lat_jump) begin
                    pc <= lat_target;
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: randomized instruction stream against a queue-based
// reference model; a monitor matches observed FETCH/HALT/FAULT entries to expectations.
module tb_pc_sequencer;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, fetch_ack = 1'b0;
    logic op_jump = 1'b0, op_call = 1'b0, op_ret = 1'b0, op_halt = 1'b0;
    logic [W-1:0] target = '0;
    logic fetch_req, busy, halted, fault;
    logic [W-1:0] fetch_addr, pc;
    logic [2:0] sp;

    pc_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .fetch_ack(fetch_ack),
        .op_jump(op_jump), .op_call(op_call), .op_ret(op_ret), .op_halt(op_halt),
        .target(target), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .pc(pc),
        .sp(sp), .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = new FETCH, 1 = HALT entered, 2 = FAULT entered
    typedef struct {int kind; int cyc; int pc; int sp;} exp_t;
    exp_t q[$];

    int  m_pc;
    int  stk[$];
    int  m_st;               // 0 idle, 1 running, 2 halted, 3 faulted
    bit  tmo  = 1'b0;
    bit  done = 1'b0;
    int  n_chk = 0, n_fail = 0;

    task automatic junk();
        op_jump = 1'($urandom); op_call = 1'($urandom);
        op_ret  = 1'($urandom); op_halt = 1'($urandom);
        target  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; fetch_ack = 1'b0; junk();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; fetch_ack = 1'b0; reset = 1'b0;
        m_pc = 0; stk.delete(); m_st = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        if (m_st == 0) begin
            q.push_back('{0, cyc + 1, m_pc, stk.size()});
            m_st = 1;
        end else if (m_st == 2) begin
            m_pc = (m_pc + 1) % 256;
            q.push_back('{0, cyc + 1, m_pc, stk.size()});
            m_st = 1;
        end
    endtask

    task automatic instr(input bit j, input bit c, input bit r, input bit h,
                         input int tgt, input int waits, input bit abort = 1'b0);
        int w = 0;
        int n = 0;
        int k;
        forever begin
            @(negedge clk);
            start = 1'b0; fetch_ack = 1'b0; junk();
            if (fetch_req) begin
                if (w == waits) break;
                w++;
            end
            n++;
            if (n > 50) begin tmo = 1'b1; return; end
        end
        fetch_ack = 1'b1;
        op_jump = j; op_call = c; op_ret = r; op_halt = h; target = 8'(tgt);
        if (abort) begin
            @(negedge clk);
            fetch_ack = 1'b0; junk(); reset = 1'b0;
            m_pc = 0; stk.delete(); m_st = 0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            return;
        end
        k = 0;
        if (h) begin
            k = 1; m_st = 2;
        end else if (r) begin
            if (stk.size() == 0) begin k = 2; m_st = 3; end
            else m_pc = stk.pop_back();
        end else if (c) begin
            if (stk.size() == D) begin k = 2; m_st = 3; end
            else begin stk.push_back((m_pc + 1) % 256); m_pc = tgt; end
        end else if (j) begin
            m_pc = tgt;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
        q.push_back('{k, cyc + 2, m_pc, stk.size()});
        @(negedge clk);
        fetch_ack = 1'b0; junk();
    endtask

    // Stimulus
    initial begin
        m_pc = 0; m_st = 0;
        do_reset();
        do_start();
        repeat (3) instr(0, 0, 0, 0, 0, 0);
        instr(1, 0, 0, 0, 8'h40, 0);
        instr(0, 0, 0, 0, 0, 3);
        instr(1, 0, 0, 0, 8'hFD, 0);
        repeat (3) instr(0, 0, 0, 0, 0, 0);
        instr(1, 0, 0, 0, 8'h10, 0);
        instr(0, 1, 0, 0, 8'h80, 0);
        instr(0, 0, 1, 0, 0, 0);
        instr(1, 0, 0, 0, 8'hFF, 0);
        instr(0, 1, 0, 0, 8'h05, 0);
        instr(0, 0, 1, 0, 0, 0);
        repeat (4) instr(0, 1, 0, 0, $urandom_range(0, 255), 0);
        repeat (4) instr(0, 0, 1, 0, 0, 1);
        repeat (5) instr(0, 1, 0, 0, $urandom_range(0, 255), 0);
        idle(2); do_start(); idle(3);
        do_reset();
        do_start();
        instr(0, 0, 1, 0, 0, 0);
        idle(3);
        do_reset();
        do_start();
        instr(1, 0, 0, 0, 7, 0);
        instr(1, 0, 0, 1, 8'h33, 0);
        idle(2); do_start();
        instr(1, 1, 0, 0, 8'h20, 0);
        instr(0, 1, 0, 0, 8'h90, 0, 1'b1);
        idle(2); do_start();
        repeat (300) begin
            bit j, c, r, h;
            h = ($urandom_range(0, 99) < 4);
            r = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 4) == 0);
            j = ($urandom_range(0, 2) == 0);
            instr(j, c, r, h, $urandom_range(0, 255), $urandom_range(0, 2));
            if (tmo) break;
            if (m_st == 2) begin
                idle($urandom_range(1, 3)); do_start();
            end else if (m_st == 3) begin
                idle(2); do_start(); idle(2);
                do_reset(); do_start();
            end
        end
        idle(5);
        done = 1'b1;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e, cur;
        bit pf = 0, ph = 0, pfl = 0, pr = 0;
        int k;
        cur = '{0, 0, 0, 0};
        while (!done) begin
            @(clk); #1;
            if (!clk) begin
                if (!reset) chk("reset_outputs_async", {fetch_req, busy, halted, fault, sp, pc}, 0);
                continue;
            end
            if (!reset) begin
                chk("reset_outputs", {fetch_req, busy, halted, fault, sp, pc}, 0);
                cur = '{0, 0, 0, 0};
                pf = 0; ph = 0; pfl = 0; pr = 0;
                continue;
            end
            if (!pr) chk("release_idle", {fetch_req, busy, halted, fault}, 0);
            k = -1;
            if (fetch_req && !pf)    k = 0;
            else if (halted && !ph)  k = 1;
            else if (fault && !pfl)  k = 2;
            if (k >= 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", k, -1);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", k, e.kind);
                    chk("event_cycle", cyc, e.cyc);
                    chk("fetch_addr", fetch_addr, e.pc);
                    chk("event_sp", sp, e.sp);
                    chk("event_flags", {fetch_req, busy, halted, fault},
                        (e.kind == 0) ? 4'b1100 : (e.kind == 1) ? 4'b0010 : 4'b0001);
                    cur = e;
                end
            end
            chk("pc_hold", pc, cur.pc);
            chk("sp_hold", sp, cur.sp);
            if (q.size() > 0 && cyc > q[0].cyc) begin
                chk("event_missing", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            pf = fetch_req; ph = halted; pfl = fault; pr = 1;
        end
        chk("timeout", int'(tmo), 0);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
